// File: rtl/signed_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// signed_multiplier_pkg
// Shared datapath types, default width and two's-complement helpers.
// Revision: 1.0
// ============================================================================
package signed_multiplier_pkg;

   localparam int W_DEFAULT = 16;
   // Helpers work on this width; callers zero-extend and keep the low bits.
   localparam int NEG_W     = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   function automatic logic [NEG_W-1:0] twos_negate(input logic [NEG_W-1:0] x);
      return ~x + {{(NEG_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [NEG_W-1:0] twos_mag(input logic [NEG_W-1:0] x,
                                                 input logic             sign);
      return sign ? twos_negate(x) : x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/signed_multiplier_if.sv
`default_nettype none
// ============================================================================
// signed_multiplier_if
// Operand (a, b) and result (dout) stream channels of the multiplier.
// Revision: 1.0
// ============================================================================
interface signed_multiplier_if
   import signed_multiplier_pkg::*;
#(
   parameter int W = W_DEFAULT
);
   logic [W-1:0]   s_axis_a_tdata;
   logic           s_axis_a_tvalid;
   logic           s_axis_a_tready;
   logic [W-1:0]   s_axis_b_tdata;
   logic           s_axis_b_tvalid;
   logic           s_axis_b_tready;
   logic [2*W-1:0] m_axis_dout_tdata;
   logic           m_axis_dout_tvalid;
   logic           m_axis_dout_tready;

   modport slave (
      input  s_axis_a_tdata, s_axis_a_tvalid,
      output s_axis_a_tready,
      input  s_axis_b_tdata, s_axis_b_tvalid,
      output s_axis_b_tready,
      output m_axis_dout_tdata, m_axis_dout_tvalid,
      input  m_axis_dout_tready
   );

   modport master (
      output s_axis_a_tdata, s_axis_a_tvalid,
      input  s_axis_a_tready,
      output s_axis_b_tdata, s_axis_b_tvalid,
      input  s_axis_b_tready,
      input  m_axis_dout_tdata, m_axis_dout_tvalid,
      output m_axis_dout_tready
   );
endinterface
`default_nettype wire

// File: rtl/signed_multiplier_twos_abs.sv
`default_nettype none
// ============================================================================
// signed_multiplier_twos_abs
// Combinational sign and magnitude of a W-bit two's-complement value.
// Revision: 1.0
// ============================================================================
module signed_multiplier_twos_abs
   import signed_multiplier_pkg::*;
#(
   parameter int W = W_DEFAULT
)(
   input  logic [W-1:0] i_x,
   output logic         o_sign,
   output logic [W-1:0] o_mag
);

   logic [NEG_W-1:0] x_ext;
   logic [NEG_W-1:0] mag_ext;

   always_comb begin
      x_ext          = '0;
      x_ext[W-1:0]   = i_x;
      mag_ext        = twos_mag(x_ext, i_x[W-1]);
   end

   assign o_sign = i_x[W-1];
   // Most negative input yields 2^(W-1), which still fits as W-bit unsigned.
   assign o_mag  = mag_ext[W-1:0];

   generate
      if (W < NEG_W) begin : g_hi_unused
         logic unused_hi;
         assign unused_hi = ^mag_ext[NEG_W-1:W];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/signed_multiplier.sv
`default_nettype none
// ============================================================================
// signed_multiplier
// Sequential signed WxW multiplier: magnitudes, W-step shift-add, sign restore.
// Revision: 1.0
// ============================================================================
module signed_multiplier
   import signed_multiplier_pkg::*;
#(
   parameter int W = W_DEFAULT
)(
   input  logic                aclk,
   input  logic                rst,
   signed_multiplier_if.slave  axis
);

   localparam int P_W   = 2 * W;
   localparam int CNT_W = $clog2(W);

   state_e           state_q,  state_d;
   logic [W-1:0]     a_mag_q,  a_mag_d;
   logic [W-1:0]     b_mag_q,  b_mag_d;
   logic             neg_q,    neg_d;
   logic [P_W-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [P_W-1:0]   tdata_q,  tdata_d;
   logic             tvalid_q, tvalid_d;
   logic             ready_q,  ready_d;

   logic             a_sign, b_sign;
   logic [W-1:0]     a_mag,  b_mag;
   logic [P_W-1:0]   addend;
   logic [P_W-1:0]   acc_sum;
   logic [NEG_W-1:0] sum_ext;
   logic [NEG_W-1:0] sum_neg;
   logic [P_W-1:0]   result;

   signed_multiplier_twos_abs #(.W(W)) u_abs_a (
      .i_x    (axis.s_axis_a_tdata),
      .o_sign (a_sign),
      .o_mag  (a_mag)
   );

   signed_multiplier_twos_abs #(.W(W)) u_abs_b (
      .i_x    (axis.s_axis_b_tdata),
      .o_sign (b_sign),
      .o_mag  (b_mag)
   );

   always_comb begin
      addend             = b_mag_q[cnt_q] ? ({{W{1'b0}}, a_mag_q} << cnt_q) : '0;
      acc_sum            = acc_q + addend;
      sum_ext            = '0;
      sum_ext[P_W-1:0]   = acc_sum;
      sum_neg            = twos_negate(sum_ext);
      // Zero product keeps a positive sign so -0 never appears.
      result             = (neg_q && (acc_sum != '0)) ? sum_neg[P_W-1:0] : acc_sum;
   end

   generate
      if (P_W < NEG_W) begin : g_res_unused
         logic unused_hi;
         assign unused_hi = ^sum_neg[NEG_W-1:P_W];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      ready_d  = ready_q;

      case (state_q)
         ST_IDLE: begin
            // Join: both operand channels must be valid on the same edge.
            if (axis.s_axis_a_tvalid && axis.s_axis_b_tvalid) begin
               a_mag_d = a_mag;
               b_mag_d = b_mag;
               neg_d   = a_sign ^ b_sign;
               acc_d   = '0;
               cnt_d   = '0;
               ready_d = 1'b0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
               tdata_d  = result;
               tvalid_d = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (axis.m_axis_dout_tready) begin
               tvalid_d = 1'b0;
               ready_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         ready_q  <= ready_d;
      end
   end

   assign axis.s_axis_a_tready    = ready_q;
   assign axis.s_axis_b_tready    = ready_q;
   assign axis.m_axis_dout_tdata  = tdata_q;
   assign axis.m_axis_dout_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_multiplier.sv
`default_nettype none
// ============================================================================
// tb_signed_multiplier
// Vector table plus hand-written join, backpressure and reset sequences.
// Revision: 1.0
// ============================================================================
module tb_signed_multiplier;
   import signed_multiplier_pkg::*;

   localparam int W   = 16;
   localparam int P_W = 2 * W;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [P_W-1:0] p;
   } vec_t;

   logic aclk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [P_W-1:0] exp_q[$];
   vec_t vecs[10];

   always #5 aclk = ~aclk;

   signed_multiplier_if #(.W(W)) axis ();

   signed_multiplier #(.W(W)) dut (
      .aclk (aclk),
      .rst  (rst),
      .axis (axis)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every output handshake pops one expected product.
   always @(negedge aclk) begin
      if (rst === 1'b0 && axis.m_axis_dout_tvalid === 1'b1 && axis.m_axis_dout_tready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got 0x%0h, expected no output", axis.m_axis_dout_tdata);
         end else begin
            check("product", axis.m_axis_dout_tdata, exp_q.pop_front());
         end
      end
   end

   function automatic logic [P_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [P_W-1:0] p;
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return p;
   endfunction

   // Called just after an accept edge; counts edges until tvalid is seen.
   task automatic wait_result(input string tag);
      int lat = 0;
      while (lat < 100) begin
         @(posedge aclk); #1;
         lat++;
         if (axis.m_axis_dout_tvalid === 1'b1) break;
      end
      check({tag, "_latency"}, 64'(lat), 64'(W));
   endtask

   // Called at posedge+1; performs one full transaction with tready high.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [P_W-1:0] p, input string tag);
      check({tag, "_treadys"}, {axis.s_axis_a_tready, axis.s_axis_b_tready}, 2'b11);
      axis.s_axis_a_tdata     = a;
      axis.s_axis_b_tdata     = b;
      axis.s_axis_a_tvalid    = 1'b1;
      axis.s_axis_b_tvalid    = 1'b1;
      axis.m_axis_dout_tready = 1'b1;
      @(posedge aclk);
      exp_q.push_back(p);
      #1;
      axis.s_axis_a_tvalid = 1'b0;
      axis.s_axis_b_tvalid = 1'b0;
      axis.s_axis_a_tdata  = W'($urandom);
      axis.s_axis_b_tdata  = W'($urandom);
      wait_result(tag);
      @(posedge aclk); #1;
      check({tag, "_pulse"}, axis.m_axis_dout_tvalid, 1'b0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         seen_valid;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
      vecs[1] = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1};
      vecs[2] = '{16'hFFFD, 16'hFFFB, 32'h0000000F};
      vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
      vecs[4] = '{16'h8000, 16'h7FFF, 32'hC0008000};
      vecs[5] = '{16'h0000, 16'hFFF9, 32'h00000000};
      vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      vecs[7] = '{16'hFFFF, 16'h8000, 32'h00008000};
      vecs[8] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
      vecs[9] = '{16'h1234, 16'hFFFF, 32'hFFFFEDCC};

      rst                     = 1'b1;
      axis.s_axis_a_tdata     = '0;
      axis.s_axis_b_tdata     = '0;
      axis.s_axis_a_tvalid    = 1'b0;
      axis.s_axis_b_tvalid    = 1'b0;
      axis.m_axis_dout_tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_tvalid", axis.m_axis_dout_tvalid, 1'b0);
      check("reset_tdata", axis.m_axis_dout_tdata, '0);
      check("reset_treadys", {axis.s_axis_a_tready, axis.s_axis_b_tready}, 2'b11);
      rst = 1'b0;
      @(posedge aclk); #1;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
      end

      // Only a valid: nothing may be consumed; a changes every cycle.
      axis.s_axis_a_tdata  = 16'd5;
      axis.s_axis_a_tvalid = 1'b1;
      repeat (5) begin
         @(posedge aclk); #1;
         check("join_single_valid",
               {axis.s_axis_a_tready, axis.s_axis_b_tready, axis.m_axis_dout_tvalid}, 3'b110);
         axis.s_axis_a_tdata = axis.s_axis_a_tdata + 16'd1;
      end
      run_op(16'd11, 16'hFFFE, 32'hFFFFFFEA, "join");

      // Backpressure, with the next operand pair waiting throughout HOLD.
      axis.s_axis_a_tdata     = 16'hFFF9;
      axis.s_axis_b_tdata     = 16'd300;
      axis.s_axis_a_tvalid    = 1'b1;
      axis.s_axis_b_tvalid    = 1'b1;
      axis.m_axis_dout_tready = 1'b0;
      @(posedge aclk);
      exp_q.push_back(32'hFFFFF7CC);
      #1;
      axis.s_axis_a_tdata = 16'd9;
      axis.s_axis_b_tdata = 16'hFFF7;
      wait_result("bp");
      repeat (10) begin
         @(posedge aclk); #1;
         check("bp_hold",
               {axis.m_axis_dout_tvalid, axis.s_axis_a_tready, axis.s_axis_b_tready,
                axis.m_axis_dout_tdata},
               {1'b1, 2'b00, 32'hFFFFF7CC});
      end
      axis.m_axis_dout_tready = 1'b1;
      @(posedge aclk); #1;
      check("bp_after_handshake",
            {axis.m_axis_dout_tvalid, axis.s_axis_a_tready, axis.s_axis_b_tready}, 3'b011);
      @(posedge aclk);
      exp_q.push_back(32'hFFFFFFAF);
      #1;
      check("bp_second_accept", {axis.s_axis_a_tready, axis.s_axis_b_tready}, 2'b00);
      axis.s_axis_a_tvalid = 1'b0;
      axis.s_axis_b_tvalid = 1'b0;
      wait_result("bp2");
      @(posedge aclk); #1;

      // Reset sampled on the 7th CALC edge of 100*200.
      axis.s_axis_a_tdata  = 16'd100;
      axis.s_axis_b_tdata  = 16'd200;
      axis.s_axis_a_tvalid = 1'b1;
      axis.s_axis_b_tvalid = 1'b1;
      @(posedge aclk); #1;
      axis.s_axis_a_tvalid = 1'b0;
      axis.s_axis_b_tvalid = 1'b0;
      repeat (6) @(posedge aclk);
      #1;
      rst = 1'b1;
      @(posedge aclk); #1;
      rst = 1'b0;
      check("rst_mid_calc",
            {axis.m_axis_dout_tvalid, axis.s_axis_a_tready, axis.s_axis_b_tready,
             axis.m_axis_dout_tdata},
            {1'b0, 2'b11, 32'h0});
      seen_valid = 1'b0;
      repeat (W + 4) begin
         @(posedge aclk); #1;
         if (axis.m_axis_dout_tvalid !== 1'b0) seen_valid = 1'b1;
      end
      check("rst_no_partial_output", seen_valid, 1'b0);
      run_op(16'd7, 16'd9, 32'h0000003F, "after_rst");

      repeat (3) @(posedge aclk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
